// File: rtl/input_debouncer_if.sv
// Raw input, enable and debounced outputs of the input debouncer.
// The master drives the raw side; the slave returns clean level and pulses.
interface input_debouncer_if;
  logic in_async;
  logic en;
  logic out_level;
  logic rise_p;
  logic fall_p;
  logic busy;

  modport master (
    output in_async,
    output en,
    input  out_level,
    input  rise_p,
    input  fall_p,
    input  busy
  );

  modport slave (
    input  in_async,
    input  en,
    output out_level,
    output rise_p,
    output fall_p,
    output busy
  );
endinterface

// File: rtl/input_debouncer.sv
// Synchronizes an asynchronous input and debounces it with a stable-count FSM.
// Emits a registered level, one-cycle rise/fall pulses and a busy flag.
module input_debouncer #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input logic               clk,
  input logic               rst,
  input_debouncer_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_LO,
    CHK_HI,
    ST_HI,
    CHK_LO
  } state_t;

  localparam logic [CNT_W-1:0] TERM = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             busy_q, busy_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.in_async};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state_q)
      ST_LO: begin
        if (bus.en && s) begin
          state_d = CHK_HI;
          cnt_d   = ONE;
        end
      end
      CHK_HI: begin
        if (!bus.en || !s) begin
          state_d = ST_LO;
          cnt_d   = '0;
        end else if (cnt_q == TERM) begin
          state_d = ST_HI;
          level_d = 1'b1;
          rise_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      ST_HI: begin
        if (bus.en && !s) begin
          state_d = CHK_LO;
          cnt_d   = ONE;
        end
      end
      CHK_LO: begin
        if (!bus.en || s) begin
          state_d = ST_HI;
          cnt_d   = '0;
        end else if (cnt_q == TERM) begin
          state_d = ST_LO;
          level_d = 1'b0;
          fall_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
    endcase
    // busy is registered, so it tracks the state being entered
    busy_d = (state_d == CHK_HI) || (state_d == CHK_LO);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_LO;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.out_level = level_q;
  assign bus.rise_p    = rise_q;
  assign bus.fall_p    = fall_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_input_debouncer.sv
// Directed bench for input_debouncer with SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
// Inputs change and outputs are checked on the falling clock edge.
module tb_input_debouncer;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  input_debouncer_if bus ();

  input_debouncer #(
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int n_rise;
    int n_fall;
    int n_lvl;
    int n_busy;
    checks       = 0;
    errors       = 0;
    rst          = 1'b0;
    bus.in_async = 1'b0;
    bus.en       = 1'b1;

    // 1: async reset before any clock edge
    #2 rst = 1'b1;
    #1;
    chk("rst_level", bus.out_level, 1'b0);
    chk("rst_rise", bus.rise_p, 1'b0);
    chk("rst_fall", bus.fall_p, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    tick(1);
    rst = 1'b0;
    n_lvl  = 0;
    n_busy = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (bus.out_level) n_lvl++;
      if (bus.busy) n_busy++;
    end
    chk_int("idle_level_cnt", n_lvl, 0);
    chk_int("idle_busy_cnt", n_busy, 0);

    // 2: clean rise, then clean fall
    bus.in_async = 1'b1;
    tick(2);
    chk("rise_busy_early", bus.busy, 1'b0);
    tick(1);
    chk("rise_busy", bus.busy, 1'b1);
    tick(2);
    chk("rise_lvl_early", bus.out_level, 1'b0);
    chk("rise_p_early", bus.rise_p, 1'b0);
    tick(1);
    chk("rise_lvl", bus.out_level, 1'b1);
    chk("rise_p", bus.rise_p, 1'b1);
    chk("rise_busy_done", bus.busy, 1'b0);
    tick(1);
    chk("rise_p_clear", bus.rise_p, 1'b0);
    chk("rise_lvl_hold", bus.out_level, 1'b1);
    tick(5);
    bus.in_async = 1'b0;
    tick(5);
    chk("fall_lvl_early", bus.out_level, 1'b1);
    chk("fall_p_early", bus.fall_p, 1'b0);
    tick(1);
    chk("fall_lvl", bus.out_level, 1'b0);
    chk("fall_p", bus.fall_p, 1'b1);
    chk("fall_no_rise", bus.rise_p, 1'b0);
    tick(1);
    chk("fall_p_clear", bus.fall_p, 1'b0);
    tick(5);

    // 3: bounce then hold high
    n_rise = 0;
    bus.in_async = 1'b1;
    tick(1);
    bus.in_async = 1'b0;
    tick(1);
    bus.in_async = 1'b1;
    tick(1);
    bus.in_async = 1'b0;
    tick(1);
    bus.in_async = 1'b1;
    for (int i = 5; i <= 16; i++) begin
      tick(1);
      if (bus.rise_p) n_rise++;
      if (i == 9) chk("bounce_lvl_early", bus.out_level, 1'b0);
      if (i == 10) chk("bounce_lvl", bus.out_level, 1'b1);
    end
    chk_int("bounce_rise_cnt", n_rise, 1);
    bus.in_async = 1'b0;
    tick(12);
    chk("bounce_back_low", bus.out_level, 1'b0);

    // 4: 3-cycle pulse is rejected
    n_rise = 0;
    n_fall = 0;
    n_lvl  = 0;
    n_busy = 0;
    bus.in_async = 1'b1;
    tick(3);
    bus.in_async = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      if (bus.rise_p) n_rise++;
      if (bus.fall_p) n_fall++;
      if (bus.out_level) n_lvl++;
      if (bus.busy) n_busy++;
    end
    chk_int("short_rise_cnt", n_rise, 0);
    chk_int("short_fall_cnt", n_fall, 0);
    chk_int("short_lvl_cnt", n_lvl, 0);
    chk_int("short_busy_cnt", n_busy, 2);

    // 5: enable drop aborts qualification
    bus.in_async = 1'b1;
    tick(3);
    chk("en_busy", bus.busy, 1'b1);
    bus.en = 1'b0;
    tick(1);
    chk("en_abort_busy", bus.busy, 1'b0);
    tick(3);
    chk("en_frozen_busy", bus.busy, 1'b0);
    chk("en_frozen_lvl", bus.out_level, 1'b0);
    bus.en = 1'b1;
    tick(3);
    chk("en_rise_early", bus.rise_p, 1'b0);
    tick(1);
    chk("en_rise", bus.rise_p, 1'b1);
    chk("en_lvl", bus.out_level, 1'b1);
    bus.in_async = 1'b0;
    tick(10);
    chk("en_back_low", bus.out_level, 1'b0);

    // 6: reset during qualification, release with input high
    bus.in_async = 1'b1;
    tick(4);
    chk("rstq_busy_before", bus.busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("rstq_busy", bus.busy, 1'b0);
    chk("rstq_lvl", bus.out_level, 1'b0);
    tick(2);
    rst = 1'b0;
    tick(5);
    chk("rstq_rise_early", bus.rise_p, 1'b0);
    tick(1);
    chk("rstq_rise", bus.rise_p, 1'b1);
    chk("rstq_lvl_high", bus.out_level, 1'b1);
    tick(1);
    chk("rstq_rise_clear", bus.rise_p, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
